// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and score-slice helper for the evaluation sequencer.
package nn_pkg;

    localparam int DEF_N_SAMPLES_MAX = 750;
    localparam int DEF_N_CLASSES     = 10;
    localparam int DEF_SCORE_W       = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_RUN      = 3'd2,
        S_WAIT     = 3'd3,
        S_CLASSIFY = 3'd4,
        S_UPDATE   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // Bit offset of class cls inside the packed score vector.
    function automatic int score_lsb(input int cls, input int score_w);
        return cls * score_w;
    endfunction

endpackage

// File: rtl/nn_argmax.sv
// Combinational signed argmax over the packed class scores; the lowest index wins a tie.
module nn_argmax
    import nn_pkg::*;
#(
    parameter int N_CLASSES = DEF_N_CLASSES,
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int LABEL_W   = 4
) (
    input  logic [N_CLASSES*SCORE_W-1:0] scores_i,
    output logic [LABEL_W-1:0]           idx_o
);

    logic signed [SCORE_W-1:0] best;

    // Linear scan; strict greater-than keeps the earlier class on equal scores.
    always_comb begin
        best  = $signed(scores_i[SCORE_W-1:0]);
        idx_o = '0;
        for (int c = 1; c < N_CLASSES; c++) begin
            if ($signed(scores_i[score_lsb(c, SCORE_W) +: SCORE_W]) > best) begin
                best  = $signed(scores_i[score_lsb(c, SCORE_W) +: SCORE_W]);
                idx_o = LABEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/nn_eval_sequencer.sv
// Evaluation sequencer: fetches each sample and label, starts the layer datapath,
// takes the argmax of the returned scores and counts correct predictions.
//
// Handshakes: mem_req is a level held through FETCH until a cycle with mem_valid=1,
// which completes the transfer (label captured, in_load mirrors mem_valid). layer_start
// is a single-cycle pulse; layer_done is a single-cycle pulse honoured only in WAIT,
// with scores valid in that same cycle. mem_valid outside FETCH is ignored.
module nn_eval_sequencer
    import nn_pkg::*;
#(
    parameter int N_SAMPLES_MAX = DEF_N_SAMPLES_MAX,
    parameter int N_CLASSES     = DEF_N_CLASSES,
    parameter int SCORE_W       = DEF_SCORE_W,
    parameter int ADDR_W        = $clog2(N_SAMPLES_MAX),
    parameter int CNT_W         = $clog2(N_SAMPLES_MAX + 1),
    parameter int LABEL_W       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             num_samples,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_req,
    input  logic                         mem_valid,
    input  logic [LABEL_W-1:0]           label,
    output logic                         in_load,
    output logic                         layer_start,
    input  logic                         layer_done,
    input  logic [N_CLASSES*SCORE_W-1:0] scores,
    output logic [LABEL_W-1:0]           pred,
    output logic                         pred_valid,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             accuracy,
    output state_t                       dbg_state
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [LABEL_W-1:0] label_q, label_d;
    logic [LABEL_W-1:0] pred_q, pred_d;
    logic               hit_q, hit_d;
    logic [LABEL_W-1:0] amax_idx;

    nn_argmax #(
        .N_CLASSES (N_CLASSES),
        .SCORE_W   (SCORE_W),
        .LABEL_W   (LABEL_W)
    ) u_argmax (
        .scores_i (scores),
        .idx_o    (amax_idx)
    );

    // State and datapath registers; reset drops everything, including any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            label_q <= '0;
            pred_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            label_q <= label_d;
            pred_q  <= pred_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state and Moore outputs; the index stops at n-1 so the final address stays visible.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        label_d     = label_q;
        pred_d      = pred_q;
        hit_d       = hit_q;
        mem_req     = 1'b0;
        in_load     = 1'b0;
        layer_start = 1'b0;
        pred_valid  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                done = (state_q == S_DONE);
                if (start) begin
                    n_d     = (num_samples > CNT_W'(N_SAMPLES_MAX)) ? CNT_W'(N_SAMPLES_MAX)
                                                                    : num_samples;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = (n_d == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                in_load = mem_valid;
                if (mem_valid) begin
                    label_d = label;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                layer_start = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (layer_done) begin
                    pred_d  = amax_idx;
                    state_d = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                pred_valid = 1'b1;
                // Labels outside the class range can never be matched.
                hit_d      = (pred_q == label_q) &&
                             ({1'b0, label_q} < (LABEL_W + 1)'(N_CLASSES));
                state_d    = S_UPDATE;
            end
            S_UPDATE: begin
                acc_d = acc_q + CNT_W'(hit_q);
                if (idx_q + CNT_W'(1) == n_q) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr  = ADDR_W'(idx_q);
    assign pred      = pred_q;
    assign accuracy  = acc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nn_eval_sequencer.sv
// Bench for nn_eval_sequencer: memory and datapath responders, argmax/accuracy
// reference model, per-cycle compare process and directed plus random runs.
module tb_nn_eval_sequencer;
  import nn_pkg::*;

  localparam int NMAX = 750;
  localparam int NC   = 10;
  localparam int SW   = 8;
  localparam int AW   = $clog2(NMAX);
  localparam int CW   = $clog2(NMAX + 1);
  localparam int LW   = 4;
  localparam int SV   = NC * SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_valid = 1'b0;
  logic [LW-1:0] label = '0;
  logic          in_load;
  logic          layer_start;
  logic          layer_done = 1'b0;
  logic [SV-1:0] scores = '0;
  logic [LW-1:0] pred;
  logic          pred_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] accuracy;
  state_t        dbg_state;

  nn_eval_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_valid   (mem_valid),
    .label       (label),
    .in_load     (in_load),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .scores      (scores),
    .pred        (pred),
    .pred_valid  (pred_valid),
    .busy        (busy),
    .done        (done),
    .accuracy    (accuracy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- stimulus tables and model state ----------------
  logic [SV-1:0] sc_arr  [NMAX];
  logic [LW-1:0] lab_arr [NMAX];
  int mem_lat = 0, dp_lat = 1, lat_rand = 0, stray_req_n = 0;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] pred_log[$];
  int exp_acc = 0;
  int pv_cnt = 0, busy_cnt = 0, mem_req_seen = 0;
  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference argmax: find the maximum value, then the first class holding it.
  function automatic logic [LW-1:0] ref_argmax(input logic [SV-1:0] s);
    int mx, v;
    logic found;
    logic [LW-1:0] r;
    mx = -1000; r = '0; found = 1'b0;
    for (int c = 0; c < NC; c++) begin
      v = int'($signed(s[c*SW +: SW]));
      if (v > mx) mx = v;
    end
    for (int c = 0; c < NC; c++) begin
      v = int'($signed(s[c*SW +: SW]));
      if (!found && v == mx) begin r = LW'(c); found = 1'b1; end
    end
    return r;
  endfunction

  function automatic logic [SV-1:0] rand_scores();
    logic [SV-1:0] s;
    for (int c = 0; c < NC; c++) s[c*SW +: SW] = SW'($urandom_range(0, 255));
    return s;
  endfunction

  // tgt >= 0 places a unique maximum at class tgt; tgt < 0 gives fully random scores.
  task automatic make_sample(input int a, input int lab, input int tgt);
    logic [SV-1:0] s;
    int v;
    s = rand_scores();
    if (tgt >= 0) begin
      for (int c = 0; c < NC; c++) begin
        v = $urandom_range(0, 218) - 128;
        s[c*SW +: SW] = SW'(v);
      end
      s[tgt*SW +: SW] = SW'(100);
    end
    sc_arr[a]  = s;
    lab_arr[a] = LW'(lab);
  endtask

  // ---------------- memory responder ----------------
  initial begin : mem_resp
    int wait_c;
    wait_c = -1;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      label     = LW'($urandom_range(0, 15));
      if (rst && mem_req) begin
        if (wait_c < 0) wait_c = lat_rand ? $urandom_range(0, 5) : mem_lat;
        if (wait_c == 0) begin
          mem_valid = 1'b1;
          label     = lab_arr[mem_addr];
          wait_c    = -1;
        end else begin
          wait_c--;
        end
      end else begin
        wait_c = -1;
      end
    end
  end

  // ---------------- datapath responder and model update ----------------
  initial begin : dp_resp
    int wait_c, a, stray_done;
    logic [LW-1:0] p;
    wait_c = -1; a = 0; stray_done = 0;
    forever begin
      @(negedge clk);
      layer_done = 1'b0;
      scores     = rand_scores();
      if (!rst) begin
        wait_c = -1;
      end else if (stray_req_n > stray_done && mem_req) begin
        stray_done++;
        layer_done = 1'b1;
      end else if (layer_start) begin
        wait_c = lat_rand ? $urandom_range(1, 8) : dp_lat;
        a      = int'(mem_addr);
      end else if (wait_c > 0) begin
        wait_c--;
        if (wait_c == 0) begin
          layer_done = 1'b1;
          scores     = sc_arr[a];
          p          = ref_argmax(sc_arr[a]);
          exp_q.push_back(p);
          if (p == lab_arr[a] && int'(lab_arr[a]) < NC) exp_acc++;
          wait_c = -1;
        end
      end
    end
  end

  // ---------------- per-cycle compare process ----------------
  initial begin : compare
    logic prev_req, prev_valid, prev_done;
    prev_req = 1'b0; prev_valid = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check("busy_and_done", int'(busy && done), 0);
        check("in_load", int'(in_load), int'(mem_req && mem_valid));
        if (prev_req && !prev_valid) check("mem_req_hold", int'(mem_req), 1);
        if (mem_req) begin
          mem_req_seen = 1;
          check("mem_addr", int'(mem_addr), pv_cnt);
        end
        if (busy) busy_cnt++;
        if (pred_valid) begin
          pv_cnt++;
          pred_log.push_back(pred);
          if (exp_q.size() == 0) check("pred_unexpected", 1, 0);
          else check("pred", int'(pred), int'(exp_q.pop_front()));
        end
        if (done && !prev_done) begin
          check("acc_at_done", int'(accuracy), exp_acc);
          check("pending_preds", exp_q.size(), 0);
        end
        prev_req = mem_req; prev_valid = mem_valid; prev_done = done;
      end else begin
        prev_req = 1'b0; prev_valid = 1'b0; prev_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    @(negedge clk);
    exp_q.delete(); pred_log.delete();
    exp_acc = 0; pv_cnt = 0; busy_cnt = 0; mem_req_seen = 0;
    start = 1'b1; num_samples = CW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic poke_start(input int n);
    @(negedge clk);
    start = 1'b1; num_samples = CW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    #3;
    while (!done && k < budget) begin
      @(negedge clk);
      #3;
      k++;
    end
    check("done_within_budget", int'(done), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_req"}, int'(mem_req), 0);
    check({tag, "_layer_start"}, int'(layer_start), 0);
    check({tag, "_pred_valid"}, int'(pred_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_in_load"}, int'(in_load), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_pred"}, int'(pred), 0);
    check({tag, "_accuracy"}, int'(accuracy), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n, k;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic run: labels 2,5,7, maxima at 2,4,7, zero-wait memory.
    mem_lat = 0; dp_lat = 1; lat_rand = 0;
    make_sample(0, 2, 2); make_sample(1, 5, 4); make_sample(2, 7, 7);
    run(3);
    wait_done(200);
    check("t1_accuracy", int'(accuracy), 2);
    check("t1_done", int'(done), 1);
    check("t1_busy_cycles", busy_cnt, 15);
    check("t1_pred_pulses", pv_cnt, 3);
    if (pred_log.size() == 3) begin
      check("t1_pred0", int'(pred_log[0]), 2);
      check("t1_pred1", int'(pred_log[1]), 4);
      check("t1_pred2", int'(pred_log[2]), 7);
    end

    // Zero samples, restarted from DONE.
    run(0);
    #3;
    check("t2_done_next", int'(done), 1);
    check("t2_busy", int'(busy), 0);
    check("t2_accuracy", int'(accuracy), 0);
    repeat (5) @(negedge clk);
    #3;
    check("t2_no_mem_req", mem_req_seen, 0);

    // Oversized count clamps to NMAX, every prediction correct.
    for (int a = 0; a < NMAX; a++) begin
      k = $urandom_range(0, NC - 1);
      make_sample(a, k, k);
    end
    run(1000);
    wait_done(5000);
    check("t3_pred_pulses", pv_cnt, NMAX);
    check("t3_accuracy", int'(accuracy), NMAX);
    check("t3_final_addr", int'(mem_addr), NMAX - 1);

    // Ties: all equal -> class 0; classes 4 and 9 equal maxima -> class 4.
    for (int c = 0; c < NC; c++) sc_arr[0][c*SW +: SW] = SW'(-3);
    lab_arr[0] = LW'(0);
    make_sample(1, 9, 4);
    sc_arr[1][9*SW +: SW] = SW'(100);
    run(2);
    wait_done(200);
    check("t4_pred_count", pred_log.size(), 2);
    if (pred_log.size() == 2) begin
      check("t4_pred_tie_all", int'(pred_log[0]), 0);
      check("t4_pred_tie_4_9", int'(pred_log[1]), 4);
    end
    check("t4_accuracy", int'(accuracy), 1);

    // Variable latency, stray layer_done in FETCH, start while busy.
    mem_lat = 4; dp_lat = 7;
    make_sample(0, 1, 1); make_sample(1, 3, 6); make_sample(2, 8, 8);
    run(3);
    @(negedge clk);
    stray_req_n++;
    poke_start(5);
    repeat (6) @(negedge clk);
    poke_start(1);
    wait_done(400);
    check("t5_accuracy", int'(accuracy), 2);
    check("t5_pred_pulses", pv_cnt, 3);

    // Reset during WAIT of sample 2 of 5, then a fresh 2-sample run with label 15.
    mem_lat = 0; dp_lat = 7;
    for (int a = 0; a < 5; a++) make_sample(a, a, a);
    run(5);
    k = 0; n = 0;
    while (n < 2 && k < 200) begin
      @(negedge clk);
      #3;
      if (layer_start) n++;
      k++;
    end
    check("t6_reached_sample2", n, 2);
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset("midrun_reset");
    repeat (3) @(negedge clk);
    exp_q.delete(); exp_acc = 0;
    rst = 1'b1;
    dp_lat = 1;
    make_sample(0, 3, 3); make_sample(1, 15, 5);
    run(2);
    wait_done(200);
    check("t6_accuracy", int'(accuracy), 1);
    check("t6_pred_pulses", pv_cnt, 2);

    // Randomised runs with random latencies and out-of-range labels.
    lat_rand = 1;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 25);
      for (int a = 0; a < n; a++) begin
        k = $urandom_range(0, 11);
        if (k < NC && $urandom_range(0, 9) < 6) make_sample(a, k, k);
        else make_sample(a, k, -1);
      end
      run(n);
      wait_done(2000);
      check("rand_pred_pulses", pv_cnt, n);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
